mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters: port 0 (CPU controller/datapath fetch and LDA/SDA accesses) and port 1 (DMA/program loader).
- Sits between the requesters and the memory.
- Serialises accesses and inserts a configurable number of memory wait cycles.
- Returns read data per port with a one-cycle done pulse.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEF_ADDR_W  = 13;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two memory ports.
// MEM_ARB_CPU_PRIO_EN: when defined, port 0 always wins (port 1 can starve);
// otherwise two-way round-robin against last_served.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic any_req,
    output logic winner
);

    // Winner is only meaningful while any_req is high.
    always_comb begin
        any_req = req0 | req1;
`ifdef MEM_ARB_CPU_PRIO_EN
        winner  = req0 ? PORT_CPU : PORT_DMA;
`else
        winner  = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_served;
        end else if (req1) begin
            winner = PORT_DMA;
        end
`endif
    end

`ifdef MEM_ARB_CPU_PRIO_EN
    // Fixed priority ignores the round-robin history.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory.
// Grants one access at a time, holds the memory for MEM_LAT cycles,
// then pulses done on the winning port.
// MEM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of round-robin.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winner's access
// ACCESS | memory busy for MEM_LAT cycles, cnt counts down to 0
// DONE   | one-cycle done pulse on the winning port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_served_q, last_served_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic pick;

    mem_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served_q),
        .any_req     (any_req),
        .winner      (pick)
    );

    // Next-state, datapath capture and output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        win_d         = win_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        done0         = 1'b0;
        done1         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt0          = (pick == PORT_CPU);
                    gnt1          = (pick == PORT_DMA);
                    win_d         = pick;
                    last_served_d = pick;
                    we_d          = (pick == PORT_DMA) ? we1    : we0;
                    addr_d        = (pick == PORT_DMA) ? addr1  : addr0;
                    wdata_d       = (pick == PORT_DMA) ? wdata1 : wdata0;
                    cnt_d         = LAT_M1;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_read  = ~we_q;
                // Writes strobe only once, on the last access cycle.
                mem_write = we_q && (cnt_q == 4'd0);
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (win_q == PORT_DMA) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done0   = (win_q == PORT_CPU);
                done1   = (win_q == PORT_DMA);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_served_q <= PORT_DMA;
            win_q         <= PORT_CPU;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
            win_q         <= win_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table,
// multi-cycle corner sequences and a randomized run against a cycle-count model.
module tb_mem_port_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          Clk, Reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_read, mem_write, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory behind the arbiter, with a backdoor for presetting contents.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    always @(posedge Clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end
    assign mem_rdata = mem[mem_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(posedge Clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge Clk);
        while (busy && k < 40) begin
            @(negedge Clk);
            k++;
        end
        check("wait_idle", busy, 0);
        @(posedge Clk); #1;
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    // One isolated access from IDLE; checks grant, strobe timing, done and data.
    task automatic run_single(input vec_t v);
        logic [DW-1:0] other_before;
        int n_rd, n_wr, wr_k, n_done, done_k;
        other_before = v.port ? rdata0 : rdata1;
        if (v.port) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        else        begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        @(negedge Clk);
        check("single_gnt", {gnt0, gnt1}, v.port ? 2'b01 : 2'b10);
        n_rd = 0; n_wr = 0; wr_k = 0; n_done = 0; done_k = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge Clk);
            check("single_rw_overlap", mem_read & mem_write, 0);
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++; wr_k = k;
                check("single_wr_addr", mem_addr, v.addr);
                check("single_wr_data", mem_wdata, v.wdata);
            end
            if (v.port ? done1 : done0) begin n_done++; done_k = k; end
        end
        check("single_rd_cycles", n_rd, v.we ? 0 : LAT);
        check("single_wr_cycles", n_wr, v.we ? 1 : 0);
        if (v.we) check("single_wr_cycle", wr_k, LAT);
        check("single_done_cnt", n_done, 1);
        check("single_done_cycle", done_k, LAT + 1);
        if (!v.we) check("single_rdata", v.port ? rdata1 : rdata0, v.exp_rdata);
        check("single_other_rdata", v.port ? rdata0 : rdata1, other_before);
        @(posedge Clk); #1;
        req0 = 0; req1 = 0;
        @(negedge Clk);
        check("single_idle_after", busy, 0);
        @(posedge Clk); #1;
    endtask

    vec_t tbl[8];
    int   exp_order[4];
    int   order[4];
    int   ng, nd, last_k, t_done0, t_gnt1, gnt1_early;

    // Randomized run state.
    bit            active[2], finished[2], pwe[2];
    logic [AW-1:0] paddr[2];
    logic [DW-1:0] pdata[2];
    logic [DW-1:0] ref_mem[8];
    logic [DW-1:0] exp_rdata[2];
    bit            have, gw, gwe, last, w, in_acc, exp_busy, exp_rd, exp_wr;
    bit  [1:0]     exp_g, exp_d;
    int            g, next_free;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{port:0, we:0, addr:13'h0005, wdata:16'h0000, exp_rdata:16'hA5A5};
        tbl[1] = '{port:1, we:1, addr:13'h0010, wdata:16'h1234, exp_rdata:16'h0000};
        tbl[2] = '{port:0, we:0, addr:13'h0010, wdata:16'h0000, exp_rdata:16'h1234};
        tbl[3] = '{port:1, we:0, addr:13'h0005, wdata:16'h0000, exp_rdata:16'hA5A5};
        tbl[4] = '{port:0, we:1, addr:13'h1FFF, wdata:16'hFFFF, exp_rdata:16'h0000};
        tbl[5] = '{port:1, we:0, addr:13'h1FFF, wdata:16'h0000, exp_rdata:16'hFFFF};
        tbl[6] = '{port:1, we:1, addr:13'h0010, wdata:16'h5A5A, exp_rdata:16'h0000};
        tbl[7] = '{port:0, we:0, addr:13'h0010, wdata:16'h0000, exp_rdata:16'h5A5A};
`ifdef MEM_ARB_CPU_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0; bd_we = 0; bd_addr = 0; bd_data = 0;
        Reset = 1'b0;
        #1 Reset = 1'b1;
        bd_write(13'h0005, 16'hA5A5);
        bd_write(13'h0020, 16'h1111);
        @(negedge Clk);
        check("reset_ctrl", {gnt0, gnt1, done0, done1, mem_read, mem_write, busy}, 0);
        check("reset_rdata0", rdata0, 0);
        check("reset_rdata1", rdata1, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Directed single accesses from the table.
        for (int i = 0; i < 8; i++) run_single(tbl[i]);

        // Reset in the first ACCESS cycle of a write: nothing reaches memory.
        req0 = 1; we0 = 1; addr0 = 13'h0020; wdata0 = 16'hBEEF;
        @(negedge Clk);
        check("rstmid_gnt", gnt0, 1);
        @(posedge Clk); #2;
        check("rstmid_busy_before", busy, 1);
        Reset = 1'b1; req0 = 0;
        #1;
        check("rstmid_ctrl", {mem_read, mem_write, busy, done0, done1}, 0);
        check("rstmid_rdata0", rdata0, 0);
        @(posedge Clk); #1 Reset = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge Clk);
            check("rstmid_quiet", {mem_write, done0, done1, busy}, 0);
        end
        check("rstmid_mem_unchanged", mem[13'h0020], 16'h1111);
        @(posedge Clk); #1;

        // Both ports requesting continuously right after reset.
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 13'h0001; addr1 = 13'h0002;
        ng = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge Clk);
            check("rr_gnt_overlap", gnt0 & gnt1, 0);
            if (gnt0 || gnt1) begin order[ng] = gnt1 ? 1 : 0; ng++; end
            @(posedge Clk); #1;
        end
        req0 = 0; req1 = 0;
        check("rr_count", ng, 4);
        for (int i = 0; i < 4; i++) check("rr_order", order[i], exp_order[i]);
        wait_idle();

        // req1 raised while port 0 is in ACCESS: grant follows done0 by one cycle.
        req0 = 1; we0 = 0; addr0 = 13'h0005;
        @(negedge Clk);
        check("late_gnt0", gnt0, 1);
        @(posedge Clk); #1;
        req1 = 1; we1 = 0; addr1 = 13'h0005;
        t_done0 = -1; t_gnt1 = -1; gnt1_early = 0;
        for (int k = 1; k < 20 && t_gnt1 < 0; k++) begin
            @(negedge Clk);
            if (gnt1 && t_done0 < 0) gnt1_early = 1;
            if (done0) t_done0 = k;
            if (gnt1) t_gnt1 = k;
            @(posedge Clk); #1;
            if (t_done0 >= 0) req0 = 0;
        end
        check("late_no_early_gnt1", gnt1_early, 0);
        check("late_done0_cycle", t_done0, LAT + 1);
        check("late_gnt1_cycle", t_gnt1, LAT + 2);
        for (int k = 0; k < 20 && !done1; k++) @(negedge Clk);
        check("late_done1", done1, 1);
        @(posedge Clk); #1 req1 = 0;
        wait_idle();

        // Back-to-back reads on port 0.
        req0 = 1; we0 = 0; addr0 = 13'h0003;
        last_k = -1; nd = 0;
        for (int k = 0; k < 4 * (LAT + 2) + 1; k++) begin
            @(negedge Clk);
            check("b2b_rw_overlap", mem_read & mem_write, 0);
            if (done0) begin
                if (last_k >= 0) check("b2b_gap", k - last_k, LAT + 2);
                last_k = k; nd++;
            end
            @(posedge Clk); #1;
        end
        req0 = 0;
        check("b2b_dones", nd, 4);
        wait_idle();

        // Randomized traffic against the cycle-count model.
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 16'(i * 16'h1357 + 16'h0101);
            bd_write(AW'(i), ref_mem[i]);
        end
        do_reset();
        exp_rdata[0] = 0; exp_rdata[1] = 0;
        last = 1; have = 0; g = 0; next_free = 0; gw = 0; gwe = 0; ga = 0; gd = 0;
        for (int p = 0; p < 2; p++) begin
            active[p] = 0; finished[p] = 0; pwe[p] = 0; paddr[p] = 0; pdata[p] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (finished[p]) begin active[p] = 0; finished[p] = 0; end
                if (!active[p] && $urandom_range(0, 2) == 0) begin
                    active[p] = 1;
                    pwe[p]    = 1'($urandom_range(0, 1));
                    paddr[p]  = AW'($urandom_range(0, 7));
                    pdata[p]  = 16'($urandom);
                end
            end
            req0 = active[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pdata[0];
            req1 = active[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pdata[1];
            @(negedge Clk);
            exp_g = 2'b00;
            if (c >= next_free && (active[0] || active[1])) begin
`ifdef MEM_ARB_CPU_PRIO_EN
                w = active[0] ? 1'b0 : 1'b1;
`else
                if (active[0] && active[1]) w = ~last;
                else w = active[1];
`endif
                exp_g[w] = 1'b1;
                have = 1; g = c; gw = w; gwe = pwe[w]; ga = paddr[w]; gd = pdata[w];
                last = w; next_free = c + LAT + 2;
            end
            in_acc   = have && c > g && c <= g + LAT;
            exp_busy = have && c > g && c <= g + LAT + 1;
            exp_rd   = in_acc && !gwe;
            exp_wr   = in_acc && gwe && (c == g + LAT);
            exp_d    = 2'b00;
            if (have && c == g + LAT + 1) begin
                exp_d[gw] = 1'b1;
                if (gwe) ref_mem[ga[2:0]] = gd;
                else exp_rdata[gw] = ref_mem[ga[2:0]];
            end
            check("rand_ctrl", {gnt1, gnt0, done1, done0, busy, mem_read, mem_write},
                  {exp_g[1], exp_g[0], exp_d[1], exp_d[0], exp_busy, exp_rd, exp_wr});
            if (in_acc) check("rand_addr", mem_addr, ga);
            if (exp_wr) check("rand_wdata", mem_wdata, gd);
            check("rand_rdata0", rdata0, exp_rdata[0]);
            check("rand_rdata1", rdata1, exp_rdata[1]);
            finished[0] = exp_d[0];
            finished[1] = exp_d[1];
            @(posedge Clk); #1;
        end
        req0 = 0; req1 = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
